// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared types and constants for the sprite pipeline stages.
//   - FRAC_W_DEFAULT : default number of fractional bits in scale steps
//   - span_state_e   : control states of the span generator
//   - scale_mode_e   : coarse classification of a scale step
//   - colour_table_e : colour lookup table selection used by later stages
//   - scale_mode_of  : helper that classifies a step value at the default
//                      fractional width
// ---------------------------------------------------------------------------
package gpu_pkg;

    localparam int FRAC_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        SPAN_IDLE   = 2'd0,
        SPAN_RUN    = 2'd1,
        SPAN_FINISH = 2'd2
    } span_state_e;

    typedef enum logic [1:0] {
        SCALE_1X   = 2'd0,
        SCALE_UP   = 2'd1,
        SCALE_DOWN = 2'd2
    } scale_mode_e;

    typedef enum logic [1:0] {
        CTAB_DIRECT = 2'd0,
        CTAB_PAL4   = 2'd1,
        CTAB_PAL8   = 2'd2
    } colour_table_e;

    // A step of exactly one integer unit copies 1:1; smaller steps revisit
    // source pixels (upscale), larger steps skip them (downscale).
    function automatic scale_mode_e scale_mode_of(input logic [31:0] step);
        scale_mode_e mode;
        if (step == (32'd1 << FRAC_W_DEFAULT)) begin
            mode = SCALE_1X;
        end else if (step < (32'd1 << FRAC_W_DEFAULT)) begin
            mode = SCALE_UP;
        end else begin
            mode = SCALE_DOWN;
        end
        return mode;
    endfunction

endpackage

// File: rtl/gpu_fixed_stepper.sv
// ---------------------------------------------------------------------------
// gpu_fixed_stepper
// One unsigned fixed-point accumulator used to walk a source axis.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   load_i       : capture start_i as both accumulator and base, and step_i
//   start_i      : integer start coordinate (fraction starts at zero)
//   step_i       : fixed-point step with FRAC_W fractional bits
//   advance_i    : add the captured step to the accumulator
//   rewind_i     : return the accumulator to the captured base
//   int_o        : integer part of the accumulator
// The accumulator wraps modulo 2^(SS_W+FRAC_W).
// ---------------------------------------------------------------------------
module gpu_fixed_stepper #(
    parameter int SS_W   = 32,
    parameter int FRAC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [SS_W-1:0] start_i,
    input  logic [SS_W-1:0] step_i,
    input  logic            advance_i,
    input  logic            rewind_i,
    output logic [SS_W-1:0] int_o
);

    localparam int ACC_W = SS_W + FRAC_W;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] base_q;
    logic [ACC_W-1:0] step_q;

    // Accumulator register. Load takes priority so a new command always
    // starts cleanly; rewind and advance are mutually exclusive in practice
    // but rewind wins if both are ever raised together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            base_q <= '0;
            step_q <= '0;
        end else if (load_i) begin
            acc_q  <= {start_i, {FRAC_W{1'b0}}};
            base_q <= {start_i, {FRAC_W{1'b0}}};
            step_q <= ACC_W'(step_i);
        end else if (rewind_i) begin
            acc_q <= base_q;
        end else if (advance_i) begin
            acc_q <= acc_q + step_q;
        end
    end

    assign int_o = acc_q[ACC_W-1:FRAC_W];

endmodule

// File: rtl/gpu_span_generator.sv
// ---------------------------------------------------------------------------
// gpu_span_generator
// Walks a destination rectangle in raster order and emits one
// (sprite-sheet x/y, screen x/y) pair per pixel, with fixed-point scaling,
// mirroring and an inclusive clip window.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   re_*                     : command channel (valid/ready)
//   clip_x0/y0/x1/y1         : inclusive clip window, captured on accept
//   se_*                     : pixel channel (valid/ready), registered
//   busy                     : a command is being processed
//   done                     : one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module gpu_span_generator
    import gpu_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int SS_W    = 32,
    parameter int FRAC_W  = FRAC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               re_valid,
    output logic               re_ready,
    input  logic [COORD_W-1:0] re_dst_x,
    input  logic [COORD_W-1:0] re_dst_y,
    input  logic [COORD_W-1:0] re_width,
    input  logic [COORD_W-1:0] re_height,
    input  logic [SS_W-1:0]    re_src_x,
    input  logic [SS_W-1:0]    re_src_y,
    input  logic [SS_W-1:0]    re_step_x,
    input  logic [SS_W-1:0]    re_step_y,
    input  logic               re_mirror_x,
    input  logic               re_mirror_y,
    input  logic [COORD_W-1:0] clip_x0,
    input  logic [COORD_W-1:0] clip_y0,
    input  logic [COORD_W-1:0] clip_x1,
    input  logic [COORD_W-1:0] clip_y1,
    output logic [SS_W-1:0]    se_sprite_sheet_x,
    output logic [SS_W-1:0]    se_sprite_sheet_y,
    output logic [COORD_W-1:0] se_screen_x,
    output logic [COORD_W-1:0] se_screen_y,
    output logic               se_valid,
    input  logic               se_ready,
    output logic               busy,
    output logic               done
);

    span_state_e state_q;

    logic reReady_q;
    logic busy_q;
    logic done_q;
    logic seValid_q;

    logic [COORD_W-1:0] dstX_q;
    logic [COORD_W-1:0] dstY_q;
    logic [COORD_W-1:0] width_q;
    logic [COORD_W-1:0] height_q;
    logic               mirrorX_q;
    logic               mirrorY_q;
    logic [COORD_W-1:0] clipX0_q;
    logic [COORD_W-1:0] clipY0_q;
    logic [COORD_W-1:0] clipX1_q;
    logic [COORD_W-1:0] clipY1_q;
    logic [COORD_W-1:0] i_q;
    logic [COORD_W-1:0] j_q;

    logic [SS_W-1:0]    seSsX_q;
    logic [SS_W-1:0]    seSsY_q;
    logic [COORD_W-1:0] seScrX_q;
    logic [COORD_W-1:0] seScrY_q;

    logic               accept;
    logic               outFree;
    logic               evalEn;
    logic               lastCol;
    logic               lastRow;
    logic               inClip_d;
    logic [COORD_W-1:0] offX_d;
    logic [COORD_W-1:0] offY_d;
    logic [COORD_W-1:0] scrX_d;
    logic [COORD_W-1:0] scrY_d;
    logic               xRewind;
    logic               xAdvance;
    logic               yAdvance;

    logic [SS_W-1:0] ssX;
    logic [SS_W-1:0] ssY;

    // Handshake qualifiers and the screen position of the pixel currently
    // being evaluated. The output register counts as free when it is empty
    // or being drained this cycle, which is what gives one pixel per clock.
    // Mirroring walks the offset from the far edge; all screen arithmetic
    // wraps at COORD_W bits and the clip compare runs on the wrapped values.
    always_comb begin
        accept   = (state_q == SPAN_IDLE) && reReady_q && re_valid;
        outFree  = !seValid_q || se_ready;
        evalEn   = (state_q == SPAN_RUN) && outFree;
        lastCol  = (i_q == width_q - COORD_W'(1));
        lastRow  = (j_q == height_q - COORD_W'(1));
        offX_d   = mirrorX_q ? (width_q - COORD_W'(1) - i_q) : i_q;
        offY_d   = mirrorY_q ? (height_q - COORD_W'(1) - j_q) : j_q;
        scrX_d   = dstX_q + offX_d;
        scrY_d   = dstY_q + offY_d;
        inClip_d = (scrX_d >= clipX0_q) && (scrX_d <= clipX1_q) &&
                   (scrY_d >= clipY0_q) && (scrY_d <= clipY1_q);
        xRewind  = evalEn && lastCol;
        xAdvance = evalEn && !lastCol;
        yAdvance = evalEn && lastCol;
    end

    gpu_fixed_stepper #(
        .SS_W   (SS_W),
        .FRAC_W (FRAC_W)
    ) u_stepper_x (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .start_i   (re_src_x),
        .step_i    (re_step_x),
        .advance_i (xAdvance),
        .rewind_i  (xRewind),
        .int_o     (ssX)
    );

    // The row accumulator never rewinds within a command.
    gpu_fixed_stepper #(
        .SS_W   (SS_W),
        .FRAC_W (FRAC_W)
    ) u_stepper_y (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .start_i   (re_src_y),
        .step_i    (re_step_y),
        .advance_i (yAdvance),
        .rewind_i  (1'b0),
        .int_o     (ssY)
    );

    // Control FSM with registered outputs. IDLE raises re_ready one clock
    // after reset and takes a command; RUN evaluates one (i,j) per free
    // cycle, loading the output register for in-clip pixels and letting
    // se_valid fall for clipped ones; FINISH waits for the last pixel to
    // drain before pulsing done. Empty rectangles go straight to FINISH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SPAN_IDLE;
            reReady_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seValid_q <= 1'b0;
            seSsX_q   <= '0;
            seSsY_q   <= '0;
            seScrX_q  <= '0;
            seScrY_q  <= '0;
            dstX_q    <= '0;
            dstY_q    <= '0;
            width_q   <= '0;
            height_q  <= '0;
            mirrorX_q <= 1'b0;
            mirrorY_q <= 1'b0;
            clipX0_q  <= '0;
            clipY0_q  <= '0;
            clipX1_q  <= '0;
            clipY1_q  <= '0;
            i_q       <= '0;
            j_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SPAN_IDLE: begin
                    reReady_q <= 1'b1;
                    if (accept) begin
                        dstX_q    <= re_dst_x;
                        dstY_q    <= re_dst_y;
                        width_q   <= re_width;
                        height_q  <= re_height;
                        mirrorX_q <= re_mirror_x;
                        mirrorY_q <= re_mirror_y;
                        clipX0_q  <= clip_x0;
                        clipY0_q  <= clip_y0;
                        clipX1_q  <= clip_x1;
                        clipY1_q  <= clip_y1;
                        i_q       <= '0;
                        j_q       <= '0;
                        busy_q    <= 1'b1;
                        reReady_q <= 1'b0;
                        if ((re_width == '0) || (re_height == '0)) begin
                            state_q <= SPAN_FINISH;
                        end else begin
                            state_q <= SPAN_RUN;
                        end
                    end
                end
                SPAN_RUN: begin
                    if (evalEn) begin
                        if (inClip_d) begin
                            seValid_q <= 1'b1;
                            seSsX_q   <= ssX;
                            seSsY_q   <= ssY;
                            seScrX_q  <= scrX_d;
                            seScrY_q  <= scrY_d;
                        end else begin
                            seValid_q <= 1'b0;
                        end
                        if (lastCol) begin
                            i_q <= '0;
                            if (lastRow) begin
                                state_q <= SPAN_FINISH;
                            end else begin
                                j_q <= j_q + COORD_W'(1);
                            end
                        end else begin
                            i_q <= i_q + COORD_W'(1);
                        end
                    end
                end
                SPAN_FINISH: begin
                    if (outFree) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        seValid_q <= 1'b0;
                        reReady_q <= 1'b1;
                        state_q   <= SPAN_IDLE;
                    end
                end
                default: begin
                    state_q <= SPAN_IDLE;
                end
            endcase
        end
    end

    assign re_ready          = reReady_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign se_valid          = seValid_q;
    assign se_sprite_sheet_x = seSsX_q;
    assign se_sprite_sheet_y = seSsY_q;
    assign se_screen_x       = seScrX_q;
    assign se_screen_y       = seScrY_q;

endmodule

// File: tb/tb_gpu_span_generator.sv
// ---------------------------------------------------------------------------
// tb_gpu_span_generator
// Self-checking bench for gpu_span_generator. Expected pixels are produced by
// a direct (non-incremental) model when a command is driven and queued; the
// output monitor pops and compares them on every pixel handshake.
// ---------------------------------------------------------------------------
module tb_gpu_span_generator;

    localparam int COORD_W = 16;
    localparam int SS_W    = 32;
    localparam int FRAC_W  = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               re_valid;
    logic               re_ready;
    logic [COORD_W-1:0] re_dst_x;
    logic [COORD_W-1:0] re_dst_y;
    logic [COORD_W-1:0] re_width;
    logic [COORD_W-1:0] re_height;
    logic [SS_W-1:0]    re_src_x;
    logic [SS_W-1:0]    re_src_y;
    logic [SS_W-1:0]    re_step_x;
    logic [SS_W-1:0]    re_step_y;
    logic               re_mirror_x;
    logic               re_mirror_y;
    logic [COORD_W-1:0] clip_x0;
    logic [COORD_W-1:0] clip_y0;
    logic [COORD_W-1:0] clip_x1;
    logic [COORD_W-1:0] clip_y1;
    logic [SS_W-1:0]    se_sprite_sheet_x;
    logic [SS_W-1:0]    se_sprite_sheet_y;
    logic [COORD_W-1:0] se_screen_x;
    logic [COORD_W-1:0] se_screen_y;
    logic               se_valid;
    logic               se_ready = 1'b1;
    logic               busy;
    logic               done;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [95:0] expQ[$];
    int          readyMode  = 0;
    int          readyPhase = 0;
    logic        stallPrev  = 1'b0;
    logic [95:0] heldPix    = '0;

    int doneAt;
    int firstValidAt;

    gpu_span_generator #(
        .COORD_W (COORD_W),
        .SS_W    (SS_W),
        .FRAC_W  (FRAC_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .re_valid          (re_valid),
        .re_ready          (re_ready),
        .re_dst_x          (re_dst_x),
        .re_dst_y          (re_dst_y),
        .re_width          (re_width),
        .re_height         (re_height),
        .re_src_x          (re_src_x),
        .re_src_y          (re_src_y),
        .re_step_x         (re_step_x),
        .re_step_y         (re_step_y),
        .re_mirror_x       (re_mirror_x),
        .re_mirror_y       (re_mirror_y),
        .clip_x0           (clip_x0),
        .clip_y0           (clip_y0),
        .clip_x1           (clip_x1),
        .clip_y1           (clip_y1),
        .se_sprite_sheet_x (se_sprite_sheet_x),
        .se_sprite_sheet_y (se_sprite_sheet_y),
        .se_screen_x       (se_screen_x),
        .se_screen_y       (se_screen_y),
        .se_valid          (se_valid),
        .se_ready          (se_ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: computes each pixel directly from (i,j) rather than
    // by accumulation, and queues the in-clip ones in raster order.
    task automatic pushExpected(input logic [15:0] dx, input logic [15:0] dy,
                                input logic [15:0] w, input logic [15:0] h,
                                input logic [31:0] sx, input logic [31:0] sy,
                                input logic [31:0] stx, input logic [31:0] sty,
                                input logic mx, input logic my,
                                input logic [15:0] cx0, input logic [15:0] cy0,
                                input logic [15:0] cx1, input logic [15:0] cy1);
        logic [39:0] ax;
        logic [39:0] ay;
        logic [15:0] scrX;
        logic [15:0] scrY;
        for (int j = 0; j < int'(h); j++) begin
            for (int i = 0; i < int'(w); i++) begin
                ax   = {sx, 8'd0} + 40'(i) * 40'(stx);
                ay   = {sy, 8'd0} + 40'(j) * 40'(sty);
                scrX = mx ? (dx + w - 16'd1 - 16'(i)) : (dx + 16'(i));
                scrY = my ? (dy + h - 16'd1 - 16'(j)) : (dy + 16'(j));
                if (scrX >= cx0 && scrX <= cx1 && scrY >= cy0 && scrY <= cy1) begin
                    expQ.push_back({ax[39:8], ay[39:8], scrX, scrY});
                end
            end
        end
    endtask

    // Drives one command, queues its expected pixels and completes the
    // command handshake; returns right after the accepting clock edge.
    task automatic applyStimulus(input logic [15:0] dx, input logic [15:0] dy,
                                 input logic [15:0] w, input logic [15:0] h,
                                 input logic [31:0] sx, input logic [31:0] sy,
                                 input logic [31:0] stx, input logic [31:0] sty,
                                 input logic mx, input logic my,
                                 input logic [15:0] cx0, input logic [15:0] cy0,
                                 input logic [15:0] cx1, input logic [15:0] cy1);
        bit seen;
        pushExpected(dx, dy, w, h, sx, sy, stx, sty, mx, my, cx0, cy0, cx1, cy1);
        @(posedge clk);
        #1;
        re_dst_x    = dx;
        re_dst_y    = dy;
        re_width    = w;
        re_height   = h;
        re_src_x    = sx;
        re_src_y    = sy;
        re_step_x   = stx;
        re_step_y   = sty;
        re_mirror_x = mx;
        re_mirror_y = my;
        clip_x0     = cx0;
        clip_y0     = cy0;
        clip_x1     = cx1;
        clip_y1     = cy1;
        re_valid    = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (re_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("acceptTimeout", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        re_valid = 1'b0;
    endtask

    // Counts clock edges after the accepting edge until done is seen, and
    // records the edge after which se_valid first appeared (-1 if never).
    task automatic waitDone(input int limit, output int dAt, output int fAt);
        dAt = -1;
        fAt = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (se_valid && fAt < 0) fAt = k - 1;
            if (done) begin
                dAt = k - 1;
                break;
            end
        end
        checkOutput("doneTimeout", 64'(dAt >= 0), 64'd1);
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (readyMode == 0) begin
            se_ready = 1'b1;
        end else begin
            se_ready = (readyPhase == 0);
            readyPhase = (readyPhase + 1) % 3;
        end
    end

    // Output monitor, sampled on the falling edge: checks that a stalled
    // pixel holds, and scores every pixel that will handshake this cycle.
    always @(negedge clk) begin
        logic [95:0] cur;
        logic [95:0] exp;
        cur = {se_sprite_sheet_x, se_sprite_sheet_y, se_screen_x, se_screen_y};
        if (!rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("holdSs", cur[95:32], heldPix[95:32]);
                checkOutput("holdScr", 64'(cur[31:0]), 64'(heldPix[31:0]));
                checkOutput("holdValid", 64'(se_valid), 64'd1);
            end
            if (se_valid && se_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraPixel", 64'd1, 64'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("pixSs", cur[95:32], exp[95:32]);
                    checkOutput("pixScr", 64'(cur[31:0]), 64'(exp[31:0]));
                end
            end
            stallPrev = se_valid && !se_ready;
            heldPix   = cur;
        end
    end

    initial begin
        rst         = 1'b0;
        re_valid    = 1'b0;
        re_dst_x    = '0;
        re_dst_y    = '0;
        re_width    = '0;
        re_height   = '0;
        re_src_x    = '0;
        re_src_y    = '0;
        re_step_x   = '0;
        re_step_y   = '0;
        re_mirror_x = 1'b0;
        re_mirror_y = 1'b0;
        clip_x0     = '0;
        clip_y0     = '0;
        clip_x1     = '0;
        clip_y1     = '0;

        // Reset state
        #3;
        checkOutput("rstValid", 64'(se_valid), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstReady", 64'(re_ready), 64'd0);
        checkOutput("rstScrX", 64'(se_screen_x), 64'd0);
        checkOutput("rstSsX", 64'(se_sprite_sheet_x), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("readyBeforeClk", 64'(re_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterRelease", 64'(re_ready), 64'd1);

        // 1:1 copy
        applyStimulus(16'd10, 16'd20, 16'd3, 16'd2, 32'd5, 32'd7, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        checkOutput("busyAfterAccept", 64'(busy), 64'd1);
        checkOutput("readyWhileBusy", 64'(re_ready), 64'd0);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("copyLatency", 64'(firstValidAt), 64'd1);
        checkOutput("copyDoneAt", 64'(doneAt), 64'd7);
        checkOutput("copyBusyAtDone", 64'(busy), 64'd0);
        checkOutput("copyDrained", 64'(expQ.size()), 64'd0);

        // Upscale 2x in x
        applyStimulus(16'd0, 16'd0, 16'd4, 16'd1, 32'd0, 32'd0, 32'd128, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("upDoneAt", 64'(doneAt), 64'd5);
        checkOutput("upDrained", 64'(expQ.size()), 64'd0);

        // Downscale with horizontal mirror
        applyStimulus(16'd0, 16'd0, 16'd3, 16'd1, 32'd0, 32'd0, 32'd512, 32'd256,
                      1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("mirDoneAt", 64'(doneAt), 64'd4);
        checkOutput("mirDrained", 64'(expQ.size()), 64'd0);

        // Clip window keeps the centre 2x2 of a 4x4 rectangle
        applyStimulus(16'd0, 16'd0, 16'd4, 16'd4, 32'd0, 32'd0, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'd1, 16'd1, 16'd2, 16'd2);
        checkOutput("clipQueued", 64'(expQ.size()), 64'd4);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("clipDoneAt", 64'(doneAt), 64'd17);
        checkOutput("clipDrained", 64'(expQ.size()), 64'd0);

        // Empty clip intersection: nothing emitted
        applyStimulus(16'd0, 16'd0, 16'd2, 16'd3, 32'd0, 32'd0, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'd100, 16'd100, 16'd200, 16'd200);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("emptyClipDoneAt", 64'(doneAt), 64'd7);
        checkOutput("emptyClipNoValid", 64'(firstValidAt < 0), 64'd1);

        // Backpressure with a 1,0,0 ready pattern
        readyMode  = 1;
        readyPhase = 0;
        applyStimulus(16'd30, 16'd40, 16'd3, 16'd2, 32'd5, 32'd7, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(300, doneAt, firstValidAt);
        checkOutput("bpDrained", 64'(expQ.size()), 64'd0);
        applyStimulus(16'd1, 16'd2, 16'd4, 16'd3, 32'd100, 32'd50, 32'd384, 32'd200,
                      1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(300, doneAt, firstValidAt);
        checkOutput("bp2Drained", 64'(expQ.size()), 64'd0);
        readyMode = 0;

        // Zero width
        applyStimulus(16'd5, 16'd5, 16'd0, 16'd3, 32'd0, 32'd0, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("w0DoneAt", 64'(doneAt), 64'd1);
        checkOutput("w0NoValid", 64'(firstValidAt < 0), 64'd1);

        // Screen wrap with vertical mirror
        applyStimulus(16'hFFFE, 16'd3, 16'd4, 16'd2, 32'd100, 32'd200, 32'd256, 32'd256,
                      1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("wrapDoneAt", 64'(doneAt), 64'd9);
        checkOutput("wrapDrained", 64'(expQ.size()), 64'd0);

        // Zero step replicates one source pixel
        applyStimulus(16'd7, 16'd8, 16'd3, 16'd2, 32'd9, 32'd9, 32'd0, 32'd0,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("step0DoneAt", 64'(doneAt), 64'd7);
        checkOutput("step0Drained", 64'(expQ.size()), 64'd0);

        // Reset in the middle of a command
        applyStimulus(16'd0, 16'd0, 16'd4, 16'd4, 32'd0, 32'd0, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(se_valid), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstDone", 64'(done), 64'd0);
        checkOutput("midRstReady", 64'(re_ready), 64'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midRelReady0", 64'(re_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("midRelReady1", 64'(re_ready), 64'd1);
        checkOutput("midRelDone", 64'(done), 64'd0);

        // Recovery after the aborted command
        applyStimulus(16'd50, 16'd60, 16'd1, 16'd1, 32'd3, 32'd4, 32'd256, 32'd256,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        waitDone(100, doneAt, firstValidAt);
        checkOutput("recoverDoneAt", 64'(doneAt), 64'd2);
        checkOutput("recoverDrained", 64'(expQ.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
